// File: rtl/axi4_lite_arb_manager_pkg.sv
// axi4_lite_arb_manager_pkg: shared defaults, response codes and FSM states for the arbitrated manager
package axi4_lite_arb_manager_pkg;
  localparam int DEFAULT_AXI_TIMEOUT = 256;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;
  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_W, ST_B, ST_DONE} axi_arb_state_t;
endpackage

// File: rtl/axi4_lite.sv
// axi4_lite: AXI4-Lite bus bundle with manager and subordinate views
interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport manager (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport subordinate (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_arb_manager_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the last grant
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          gnt_valid
);
  logic [LW-1:0] w_idx;
  // scan farthest candidate first so the nearest requester after last overwrites and wins
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_idx     = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = LW'((int'(last) + k) % N);
      if (req[w_idx]) begin
        gnt_idx   = w_idx;
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi4_lite_arb_manager.sv
// axi4_lite_arb_manager: round-robin arbitration of core request ports onto one AXI4-Lite manager
module axi4_lite_arb_manager
  import axi4_lite_arb_manager_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_AXI_TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  rd_en,
  input  logic [NUM_PORTS-1:0]                  wr_en,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]       wr_data,
  input  logic [NUM_PORTS-1:0][WIDTH/8-1:0]     wr_strobe,
  output logic [WIDTH-1:0]                      rd_data,
  output logic [NUM_PORTS-1:0]                  done,
  output logic [NUM_PORTS-1:0]                  access_fault,
  output logic [NUM_PORTS-1:0]                  busy,
  axi4_lite.manager                             axi_m
);
  localparam int LW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);
  axi_arb_state_t      r_state, w_next;
  logic [LW-1:0]       r_last, r_idx, w_gnt_idx;
  logic                w_gnt_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata, r_rd_data;
  logic [WIDTH/8-1:0]  r_wstrb;
  logic                r_fault, r_awdone, r_wdone;
  logic [CW-1:0]       r_cnt;
  logic                w_active, w_timeout, w_awvalid, w_wvalid, w_aw_done, w_w_done, w_fault_set;
  logic [NUM_PORTS-1:0] w_onehot;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req       (rd_en | wr_en),
    .last      (r_last),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  assign w_active    = r_state != ST_IDLE && r_state != ST_DONE;
  assign w_timeout   = w_active && r_cnt == CW'(TIMEOUT);
  assign w_awvalid   = r_state == ST_W && !r_awdone;
  assign w_wvalid    = r_state == ST_W && !r_wdone;
  assign w_aw_done   = r_awdone | (w_awvalid & axi_m.awready);
  assign w_w_done    = r_wdone | (w_wvalid & axi_m.wready);
  assign w_fault_set = w_timeout
                     | (r_state == ST_R && axi_m.rvalid && axi_m.rresp != RESP_OKAY)
                     | (r_state == ST_B && axi_m.bvalid && axi_m.bresp != RESP_OKAY);
  assign w_onehot    = NUM_PORTS'(1) << r_idx;

  assign axi_m.araddr  = r_addr;
  assign axi_m.awaddr  = r_addr;
  assign axi_m.wdata   = r_wdata;
  assign axi_m.wstrb   = r_wstrb;
  assign axi_m.arprot  = 3'b000;
  assign axi_m.awprot  = 3'b000;
  assign axi_m.arvalid = r_state == ST_AR;
  assign axi_m.rready  = r_state == ST_R;
  assign axi_m.awvalid = w_awvalid;
  assign axi_m.wvalid  = w_wvalid;
  assign axi_m.bready  = r_state == ST_B;

  assign rd_data      = r_rd_data;
  assign done         = (r_state == ST_DONE) ? w_onehot : '0;
  assign access_fault = r_fault ? done : '0;
  assign busy         = w_active ? w_onehot : '0;

  // next state: timeout aborts any bus phase; a request with both enables faults without bus activity
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_valid) w_next = (rd_en[w_gnt_idx] && wr_en[w_gnt_idx]) ? ST_DONE :
                                         rd_en[w_gnt_idx] ? ST_AR : ST_W;
      ST_AR:   w_next = w_timeout ? ST_DONE : axi_m.arready ? ST_R : ST_AR;
      ST_R:    w_next = (w_timeout || axi_m.rvalid) ? ST_DONE : ST_R;
      ST_W:    w_next = w_timeout ? ST_DONE : (w_aw_done && w_w_done) ? ST_B : ST_W;
      ST_B:    w_next = (w_timeout || axi_m.bvalid) ? ST_DONE : ST_B;
      default: w_next = ST_IDLE;
    endcase
  end

  // state, grant pointer, latched payload, handshake flags, timeout counter and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= LW'(NUM_PORTS - 1);
      r_idx     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_fault   <= 1'b0;
      r_awdone  <= 1'b0;
      r_wdone   <= 1'b0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_gnt_valid) begin
        r_idx    <= w_gnt_idx;
        r_last   <= w_gnt_idx;
        r_addr   <= addr[w_gnt_idx];
        r_wdata  <= wr_data[w_gnt_idx];
        r_wstrb  <= wr_strobe[w_gnt_idx];
        r_fault  <= rd_en[w_gnt_idx] & wr_en[w_gnt_idx];
        r_awdone <= 1'b0;
        r_wdone  <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_fault  <= r_fault | w_fault_set;
        r_awdone <= w_aw_done;
        r_wdone  <= w_w_done;
        if (w_active) r_cnt <= r_cnt + 1'b1;
        if (r_state == ST_R && axi_m.rvalid) r_rd_data <= axi_m.rdata;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_arb_manager.sv
// tb_axi4_lite_arb_manager: directed scenario tests of the arbitrated AXI4-Lite manager
module tb_axi4_lite_arb_manager;
  import axi4_lite_arb_manager_pkg::*;
  localparam int NP = 2;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]         rd_en, wr_en;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][W-1:0]  wr_data;
  logic [NP-1:0][W/8-1:0] wr_strobe;
  logic [W-1:0]          rd_data;
  logic [NP-1:0]         done, access_fault, busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(W)) axi ();

  axi4_lite_arb_manager #(.NUM_PORTS(NP), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_strobe    (wr_strobe),
    .rd_data      (rd_data),
    .done         (done),
    .access_fault (access_fault),
    .busy         (busy),
    .axi_m        (axi)
  );

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic idle_bus;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = RESP_OKAY;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = RESP_OKAY;
  endtask

  task automatic test_reset;
    checks++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 00000",
        {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    checks++;
    if ({axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== '0) begin
      errors++; $display("FAIL reset_payload: araddr %h awaddr %h wdata %h wstrb %b expected 0",
        axi.araddr, axi.awaddr, axi.wdata, axi.wstrb);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    checks++;
    if ({done, access_fault, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_status: done %b fault %b busy %b expected 0", done, access_fault, busy);
    end
  endtask

  task automatic test_read;
    idle_bus;
    axi.arready = 1'b1;
    addr[0] = 32'h0000_1000;
    rd_en = 2'b01;
    cyc;
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0000_1000) begin
      errors++; $display("FAIL read_ar_c1: arvalid %b araddr %h expected 1 00001000", axi.arvalid, axi.araddr);
    end
    checks++;
    if (done !== 2'b00 || busy !== 2'b01) begin
      errors++; $display("FAIL read_status_c1: done %b busy %b expected 00 01", done, busy);
    end
    cyc;
    checks++;
    if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0 || done !== 2'b00 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL read_r_c2: rready %b arvalid %b done %b busy %b expected 1 0 00 01",
        axi.rready, axi.arvalid, done, busy);
    end
    axi.rvalid = 1'b1;
    axi.rdata  = 32'hDEAD_BEEF;
    cyc;
    checks++;
    if (done !== 2'b01 || access_fault !== 2'b00 || busy !== 2'b00) begin
      errors++; $display("FAIL read_done_c3: done %b fault %b busy %b expected 01 00 00", done, access_fault, busy);
    end
    checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_data: got %h expected deadbeef", rd_data);
    end
    rd_en = 2'b00;
    idle_bus;
    cyc;
    checks++;
    if (done !== 2'b00) begin
      errors++; $display("FAIL read_done_pulse: got %b expected 00", done);
    end
  endtask

  task automatic test_write;
    idle_bus;
    axi.awready = 1'b1;
    addr[1] = 32'h2000_0004;
    wr_data[1] = 32'h1234_5678;
    wr_strobe[1] = 4'b0011;
    wr_en = 2'b10;
    cyc;
    checks++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || busy !== 2'b10) begin
      errors++; $display("FAIL write_valids_c1: awvalid %b wvalid %b busy %b expected 1 1 10",
        axi.awvalid, axi.wvalid, busy);
    end
    checks++;
    if (axi.awaddr !== 32'h2000_0004 || axi.wdata !== 32'h1234_5678 || axi.wstrb !== 4'b0011) begin
      errors++; $display("FAIL write_payload: awaddr %h wdata %h wstrb %b expected 20000004 12345678 0011",
        axi.awaddr, axi.wdata, axi.wstrb);
    end
    cyc;
    checks++;
    if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b1) begin
      errors++; $display("FAIL write_aw_drop: awvalid %b wvalid %b expected 0 1", axi.awvalid, axi.wvalid);
    end
    cyc;
    cyc;
    checks++;
    if (axi.wvalid !== 1'b1 || axi.bready !== 1'b0 || axi.wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL write_w_hold: wvalid %b bready %b wdata %h expected 1 0 12345678",
        axi.wvalid, axi.bready, axi.wdata);
    end
    axi.wready = 1'b1;
    cyc;
    axi.wready = 1'b0;
    checks++;
    if (axi.wvalid !== 1'b0 || axi.bready !== 1'b1 || done !== 2'b00) begin
      errors++; $display("FAIL write_b_phase: wvalid %b bready %b done %b expected 0 1 00",
        axi.wvalid, axi.bready, done);
    end
    axi.bvalid = 1'b1;
    cyc;
    checks++;
    if (done !== 2'b10 || access_fault !== 2'b00) begin
      errors++; $display("FAIL write_done: done %b fault %b expected 10 00", done, access_fault);
    end
    wr_en = 2'b00;
    idle_bus;
    cyc;
  endtask

  task automatic test_back_to_back;
    logic found;
    idle_bus;
    axi.arready = 1'b1;
    addr[0] = 32'h0000_0100;
    addr[1] = 32'h0000_0200;
    rd_en = 2'b11;
    for (int t = 0; t < 6; t++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        cyc;
        if (done !== 2'b00) found = 1'b1;
        else begin
          axi.rvalid = axi.rready;
          axi.rdata  = 32'hA000_0000 + t;
        end
      end
      axi.rvalid = 1'b0;
      checks++;
      if (!found || done !== (2'b01 << (t % 2))) begin
        errors++; $display("FAIL b2b_grant_%0d: done %b expected %b", t, done, 2'b01 << (t % 2));
      end
      checks++;
      if (rd_data !== 32'hA000_0000 + t) begin
        errors++; $display("FAIL b2b_data_%0d: got %h expected %h", t, rd_data, 32'hA000_0000 + t);
      end
      if (t == 5) rd_en = 2'b00;
    end
    idle_bus;
    cyc;
  endtask

  task automatic test_errors;
    logic found, saw_b;
    int at;
    idle_bus;
    axi.arready = 1'b1;
    axi.rresp   = RESP_SLVERR;
    rd_en = 2'b10;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc;
      if (done !== 2'b00) found = 1'b1;
      else begin
        axi.rvalid = axi.rready;
        axi.rdata  = 32'h0BAD_0BAD;
      end
    end
    checks++;
    if (!found || done !== 2'b10 || access_fault !== 2'b10) begin
      errors++; $display("FAIL slverr_read: done %b fault %b expected 10 10", done, access_fault);
    end
    rd_en = 2'b00;
    idle_bus;
    cyc;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    wr_en = 2'b01;
    found = 1'b0;
    saw_b = 1'b0;
    at = 0;
    for (int c = 1; c <= TO + 8 && !found; c++) begin
      cyc;
      if (done !== 2'b00) begin
        found = 1'b1;
        at = c;
      end else if (axi.bready === 1'b1) saw_b = 1'b1;
    end
    checks++;
    if (!found || at < TO + 1 || at > TO + 3) begin
      errors++; $display("FAIL timeout_latency: done seen %b at cycle %0d expected cycle %0d..%0d",
        found, at, TO + 1, TO + 3);
    end
    checks++;
    if (done !== 2'b01 || access_fault !== 2'b01 || axi.bready !== 1'b0 || !saw_b) begin
      errors++; $display("FAIL timeout_abort: done %b fault %b bready %b saw_bready %b expected 01 01 0 1",
        done, access_fault, axi.bready, saw_b);
    end
    wr_en = 2'b00;
    axi.bvalid = 1'b1;
    cyc;
    cyc;
    checks++;
    if (done !== 2'b00 || axi.bready !== 1'b0) begin
      errors++; $display("FAIL timeout_late_b: done %b bready %b expected 00 0", done, axi.bready);
    end
    idle_bus;
  endtask

  task automatic test_both_enables;
    logic saw_valid;
    idle_bus;
    axi.arready = 1'b1;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    rd_en = 2'b01;
    wr_en = 2'b01;
    saw_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc;
      if (axi.arvalid === 1'b1 || axi.awvalid === 1'b1 || axi.wvalid === 1'b1) saw_valid = 1'b1;
      if (c == 1) begin
        checks++;
        if (done !== 2'b01 || access_fault !== 2'b01 || busy !== 2'b00) begin
          errors++; $display("FAIL both_en_done: done %b fault %b busy %b expected 01 01 00",
            done, access_fault, busy);
        end
        rd_en = 2'b00;
        wr_en = 2'b00;
      end
    end
    checks++;
    if (saw_valid) begin
      errors++; $display("FAIL both_en_bus: valid asserted %b expected 0", saw_valid);
    end
    idle_bus;
  endtask

  task automatic test_reset_mid;
    logic found;
    idle_bus;
    axi.arready = 1'b1;
    addr[1] = 32'h0000_3000;
    rd_en = 2'b10;
    cyc;
    cyc;
    checks++;
    if (axi.rready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_r: rready %b expected 1", axi.rready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi.rready, axi.arvalid, done, access_fault, busy} !== 8'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: rready %b arvalid %b done %b fault %b busy %b rd_data %h expected 0",
        axi.rready, axi.arvalid, done, access_fault, busy, rd_data);
    end
    cyc;
    checks++;
    if (done !== 2'b00) begin
      errors++; $display("FAIL rst_mid_no_done: got %b expected 00", done);
    end
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc;
      if (done !== 2'b00) found = 1'b1;
      else begin
        axi.rvalid = axi.rready;
        axi.rdata  = 32'hCAFE_F00D;
      end
    end
    checks++;
    if (!found || done !== 2'b10 || access_fault !== 2'b00 || rd_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_mid_recover: done %b fault %b rd_data %h expected 10 00 cafef00d",
        done, access_fault, rd_data);
    end
    rd_en = 2'b00;
    idle_bus;
    cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_en = '0;
    wr_en = '0;
    addr = '0;
    wr_data = '0;
    wr_strobe = '0;
    idle_bus;
    cyc;
    cyc;
    test_reset;
    rst_n = 1'b1;
    cyc;
    test_read;
    test_write;
    test_back_to_back;
    test_errors;
    test_both_enables;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
